// File: rtl/matrix_accel_soc_pkg.sv
// Shared types and constants for the matrix-multiply SoC.
package soc_pkg;
  localparam int DATA_W         = 64;
  localparam int ELEM_W         = 16;
  localparam int ACC_W          = 32;
  localparam int LANES          = DATA_W / ELEM_W;
  localparam int RAM_WORDS_DFLT = 1024;
  localparam int RAM_AW         = $clog2(RAM_WORDS_DFLT);

  // Descriptor word layout (word 0)
  localparam int IDX_W      = 16;
  localparam int DESC_A_LSB = 0;
  localparam int DESC_B_LSB = 16;
  localparam int DESC_C_LSB = 32;

  localparam logic [7:0] DONE_CODE = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_DESC, S_LOAD_A, S_LOAD_B, S_MAC_WR, S_SEND, S_DONE
  } state_t;

  // Extract signed element k of a packed row word
  function automatic logic signed [ELEM_W-1:0] lane(input logic [DATA_W-1:0] w, input int k);
    return $signed(w[k*ELEM_W +: ELEM_W]);
  endfunction
endpackage

// File: rtl/matrix_accel_soc_periph.sv
// Peripherals of the matrix SoC: UART transmitter, RAM and control registers.

// 8N1 UART transmitter; done pulses during the last cycle of the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    frame;
  logic          bit_end;

  assign bit_end = busy && (cnt == LAST);
  assign done    = bit_end && (bit_idx == 4'd9);

  // Bit timing and line drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        tx      <= 1'b0;
        cnt     <= '0;
        bit_idx <= '0;
      end
    end else if (bit_end) begin
      cnt <= '0;
      if (bit_idx == 4'd9) begin
        busy <= 1'b0;
        tx   <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        tx      <= frame[0];
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Data bits then stop bit, shifted out LSB first
  always_ff @(posedge clk) begin
    if (!busy && start) frame <= {1'b1, data};
    else if (bit_end)   frame <= {1'b1, frame[8:1]};
  end
endmodule

// Storage array; init_val is preloaded hierarchically in simulation.
module soc_dram #(
  parameter int RAM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [63:0] init_val [RAM_WORDS];

  // Single-port synchronous read/write
  always_ff @(posedge clk) begin
    if (we) init_val[addr] <= wdata;
    rdata <= init_val[addr];
  end
endmodule

// RAM wrapper holding the storage instance.
module soc_ram #(
  parameter int RAM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  soc_dram #(.RAM_WORDS(RAM_WORDS), .AW(AW)) i_dram (
    .clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
endmodule

// Status, checksum and cycle-count registers; reg3 is reserved.
module soc_ctrl_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [7:0]  status,
  input  logic [7:0]  csum,
  input  logic [31:0] cycles,
  output logic [31:0] reg_q_o [4]
);
  // Latch end-of-run results in one shot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) reg_q_o[r] <= '0;
    end else if (we) begin
      reg_q_o[0] <= {24'h0, status};
      reg_q_o[1] <= {24'h0, csum};
      reg_q_o[2] <= cycles;
    end
  end
endmodule

// File: rtl/matrix_accel_soc.sv
// Matrix-multiply SoC top: descriptor fetch, P x P dot products, write-back,
// UART checksum byte and end-of-run flag.
module matrix_accel_soc
  import soc_pkg::*;
#(
  parameter int PRF_LOG_P    = 1,
  parameter int PRF_LOG_Q    = 2,
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tx,
  input  logic rx
);
  localparam int P  = 1 << PRF_LOG_P;
  localparam int Q  = 1 << PRF_LOG_Q;
  localparam int AW = $clog2(RAM_WORDS);

  state_t            state, state_nx;
  logic              ph, ph_nx;
  logic [2:0]        ri, rj, i_nx, j_nx;
  logic [7:0]        csum;
  logic [31:0]       cyc_cnt;
  logic [IDX_W-1:0]  a_idx, b_idx, c_idx;
  logic [DATA_W-1:0] a_row, b_row;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, rdata;
  logic              cap_desc, cap_a, cap_b;
  logic              uart_start, uart_busy, uart_done, fin;
  logic signed [ACC_W-1:0] c_val;
  logic              unused_rx;

  assign unused_rx = rx;

  // Signed dot product over the first Q lanes, wrapping modulo 2^32
  function automatic logic signed [ACC_W-1:0] dot(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic signed [ELEM_W-1:0] ea, eb;
    logic signed [ACC_W-1:0]  acc;
    acc = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < Q) begin
        ea  = lane(a, k);
        eb  = lane(b, k);
        acc = acc + ACC_W'(ea) * ACC_W'(eb);
      end
    end
    return acc;
  endfunction

  assign c_val = dot(a_row, b_row);

  // Control state: FSM, loop indices, checksum and run-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ph      <= 1'b0;
      ri      <= '0;
      rj      <= '0;
      csum    <= '0;
      cyc_cnt <= '0;
    end else begin
      state <= state_nx;
      ph    <= ph_nx;
      ri    <= i_nx;
      rj    <= j_nx;
      if (state == S_MAC_WR) csum <= csum ^ c_val[7:0];
      if (state != S_IDLE && state != S_DONE) cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  // Operand and descriptor capture from the RAM read port
  always_ff @(posedge clk) begin
    if (cap_desc) begin
      a_idx <= rdata[DESC_A_LSB +: IDX_W];
      b_idx <= rdata[DESC_B_LSB +: IDX_W];
      c_idx <= rdata[DESC_C_LSB +: IDX_W];
    end
    if (cap_a) a_row <= rdata;
    if (cap_b) b_row <= rdata;
  end

  // Next-state, RAM port and handshake decode; loads use a two-phase issue/capture
  always_comb begin
    state_nx   = state;
    ph_nx      = 1'b0;
    i_nx       = ri;
    j_nx       = rj;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    cap_desc   = 1'b0;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    uart_start = 1'b0;
    fin        = 1'b0;
    unique case (state)
      S_IDLE: state_nx = S_DESC;
      S_DESC: begin
        ph_nx = ~ph;
        if (ph) begin
          cap_desc = 1'b1;
          i_nx     = '0;
          j_nx     = '0;
          state_nx = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        ram_addr = AW'(a_idx + IDX_W'(ri));
        ph_nx    = ~ph;
        if (ph) begin
          cap_a    = 1'b1;
          state_nx = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        ram_addr = AW'(b_idx + IDX_W'(rj));
        ph_nx    = ~ph;
        if (ph) begin
          cap_b    = 1'b1;
          state_nx = S_MAC_WR;
        end
      end
      S_MAC_WR: begin
        ram_we    = 1'b1;
        ram_addr  = AW'(c_idx + (IDX_W'(ri) << PRF_LOG_P) + IDX_W'(rj));
        ram_wdata = {32'h0, c_val};
        if (rj == 3'(P - 1)) begin
          j_nx = '0;
          if (ri == 3'(P - 1)) begin
            state_nx = S_SEND;
          end else begin
            i_nx     = ri + 3'd1;
            state_nx = S_LOAD_A;
          end
        end else begin
          j_nx     = rj + 3'd1;
          state_nx = S_LOAD_B;
        end
      end
      S_SEND: begin
        uart_start = !uart_busy;
        if (uart_done) begin
          fin      = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  soc_ram #(.RAM_WORDS(RAM_WORDS), .AW(AW)) i_ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(rdata)
  );

  soc_ctrl_regs i_ctrl_regs (
    .clk(clk), .rst_n(rst_n), .we(fin), .status(DONE_CODE), .csum(csum),
    .cycles(cyc_cnt + 32'd1), .reg_q_o()
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) i_uart (
    .clk(clk), .rst_n(rst_n), .start(uart_start), .data(csum),
    .busy(uart_busy), .done(uart_done), .tx(tx)
  );
endmodule

// File: tb/tb_matrix_accel_soc.sv
// Scoreboard bench for matrix_accel_soc: expected words, registers and UART
// bytes are queued by the stimulus and checked by independent monitors.
module tb_matrix_accel_soc;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst0 = 1'b0, rst1 = 1'b0;
  logic tx0, tx1, tx_any;
  int   checks = 0, errors = 0;

  logic [9:0]  q_addr [$];
  logic [63:0] q_exp  [$];
  int          q_sel  [$];
  int          q_kind [$];
  logic [7:0]  exp_tx_q [$];
  bit          chk_req = 1'b0;

  always #5 clk = ~clk;
  assign tx_any = tx0 & tx1;

  matrix_accel_soc dut0 (.clk(clk), .rst_n(rst0), .tx(tx0), .rx(1'b1));
  matrix_accel_soc #(.PRF_LOG_P(0), .PRF_LOG_Q(0)) dut1 (
    .clk(clk), .rst_n(rst1), .tx(tx1), .rx(1'b1));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  function automatic logic [63:0] desc(input int c, input int b, input int a);
    return {16'h0, 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic wr(input int sel, input logic [9:0] a, input logic [63:0] v);
    if (sel == 0) dut0.i_ram.i_dram.init_val[a] = v;
    else          dut1.i_ram.i_dram.init_val[a] = v;
  endtask

  function automatic logic [63:0] rd(input int sel, input logic [9:0] a);
    return (sel == 0) ? dut0.i_ram.i_dram.init_val[a] : dut1.i_ram.i_dram.init_val[a];
  endfunction

  function automatic logic [31:0] reg_of(input int sel, input logic [1:0] r);
    return (sel == 0) ? dut0.i_ctrl_regs.reg_q_o[r] : dut1.i_ctrl_regs.reg_q_o[r];
  endfunction

  task automatic clear_ram(input int sel);
    for (int a = 0; a < 1024; a++) wr(sel, 10'(a), 64'h0);
  endtask

  task automatic exp_item(input int sel, input int kind, input logic [9:0] a, input logic [63:0] v);
    q_sel.push_back(sel);
    q_kind.push_back(kind);
    q_addr.push_back(a);
    q_exp.push_back(v);
  endtask

  // End-of-run register expectations; reg2 is one less than the cycle reg0 rises
  task automatic exp_regs(input int sel, input logic [7:0] cs, input int p);
    int cpt;
    cpt = 3 + p * (2 + 3 * p);
    exp_item(sel, 1, 10'd0, 64'h0000_00FF);
    exp_item(sel, 1, 10'd1, {56'h0, cs});
    exp_item(sel, 1, 10'd2, 64'(cpt + 10 * CPB));
    exp_item(sel, 1, 10'd3, 64'h0);
    exp_tx_q.push_back(cs);
  endtask

  // Basic tile: A=[1 2 3 4; 5 6 7 8], Bt=[1 1 1 1; 1 0 -1 0]
  task automatic load_basic(input int cbase);
    wr(0, 10'd0,  desc(cbase, 16'h10, 16'h08));
    wr(0, 10'd8,  pack4(1, 2, 3, 4));
    wr(0, 10'd9,  pack4(5, 6, 7, 8));
    wr(0, 10'd16, pack4(1, 1, 1, 1));
    wr(0, 10'd17, pack4(1, 0, -1, 0));
  endtask

  task automatic exp_basic(input int cbase);
    exp_item(0, 0, 10'(cbase + 0), 64'h0000_0000_0000_000A);
    exp_item(0, 0, 10'(cbase + 1), 64'h0000_0000_FFFF_FFFE);
    exp_item(0, 0, 10'(cbase + 2), 64'h0000_0000_0000_001A);
    exp_item(0, 0, 10'(cbase + 3), 64'h0000_0000_FFFF_FFFE);
    exp_regs(0, 8'h10, 2);
  endtask

  // Release reset, wait (bounded) for the done flag, check timing, then drain scoreboard
  task automatic run(input int sel, input int p);
    int  n, first_low, cpt;
    bit  done;
    logic t;
    cpt = 3 + p * (2 + 3 * p);
    n = 0; first_low = -1; done = 1'b0;
    @(negedge clk);
    if (sel == 0) rst0 = 1'b1; else rst1 = 1'b1;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      t = (sel == 0) ? tx0 : tx1;
      if (first_low < 0 && t == 1'b0) first_low = n;
      if (reg_of(sel, 2'd0) == 32'hFF) done = 1'b1;
    end
    check($sformatf("dut%0d_done_seen", sel), 64'(done), 64'd1);
    check($sformatf("dut%0d_done_cycle", sel), 64'(n), 64'(cpt + 10 * CPB + 1));
    check($sformatf("dut%0d_tx_first_low", sel), 64'(first_low), 64'(cpt + 1));
    chk_req = 1'b1;
    wait (chk_req == 1'b0);
  endtask

  task automatic reset_dut0();
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    check("abort_tx_high", 64'(tx0), 64'd1);
    check("abort_reg0_zero", 64'(reg_of(0, 2'd0)), 64'd0);
  endtask

  // Result monitor: compares queued RAM/register expectations on request
  initial begin
    logic [63:0] act;
    forever begin
      wait (chk_req);
      while (q_addr.size() > 0) begin
        int sel, kind;
        logic [9:0] a;
        logic [63:0] e;
        sel = q_sel.pop_front();
        kind = q_kind.pop_front();
        a = q_addr.pop_front();
        e = q_exp.pop_front();
        act = (kind == 0) ? rd(sel, a) : {32'h0, reg_of(sel, a[1:0])};
        check($sformatf("dut%0d_%s%0d", sel, (kind == 0) ? "word" : "reg", a), act, e);
      end
      chk_req = 1'b0;
    end
  end

  // UART monitor: decodes each 8N1 frame at mid-bit and checks it against the queue
  initial begin
    logic [7:0] b;
    logic st, sp;
    forever begin
      @(negedge tx_any);
      repeat (CPB / 2) @(negedge clk);
      st = tx_any;
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = tx_any;
      end
      repeat (CPB) @(negedge clk);
      sp = tx_any;
      if (exp_tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL uart_unexpected_frame actual=%h required=none", b);
      end else begin
        logic [7:0] e;
        e = exp_tx_q.pop_front();
        check("uart_frame", {54'h0, sp, b, st}, {54'h0, 1'b1, e, 1'b0});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx0", 64'(tx0), 64'd1);
    check("rst_tx1", 64'(tx1), 64'd1);
    for (int r = 0; r < 4; r++)
      check($sformatf("rst_reg%0d", r), 64'(reg_of(0, 2'(r))), 64'd0);

    // Basic 2x4 tile
    clear_ram(0);
    load_basic(16'h20);
    exp_basic(16'h20);
    run(0, 2);
    reset_dut0();

    // Extremes: every element -32768, sums wrap to zero
    clear_ram(0);
    wr(0, 10'd0, desc(16'h20, 16'h10, 16'h08));
    for (int a = 0; a < 2; a++) begin
      wr(0, 10'(8 + a),  64'h8000_8000_8000_8000);
      wr(0, 10'(16 + a), 64'h8000_8000_8000_8000);
    end
    for (int c = 0; c < 4; c++) exp_item(0, 0, 10'(16'h20 + c), 64'h0);
    exp_regs(0, 8'h00, 2);
    run(0, 2);
    reset_dut0();

    // Reset during the second MAC_WR, then a clean rerun
    clear_ram(0);
    load_basic(16'h20);
    @(negedge clk);
    rst0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst0 = 1'b0;
    #1;
    check("midrun_tx_high", 64'(tx0), 64'd1);
    check("midrun_reg0_zero", 64'(reg_of(0, 2'd0)), 64'd0);
    check("midrun_c0_kept", rd(0, 10'h20), 64'h0000_0000_0000_000A);
    check("midrun_c1_unwritten", rd(0, 10'h21), 64'h0);
    exp_basic(16'h20);
    run(0, 2);
    reset_dut0();

    // C index at the last RAM word wraps to words 0..2
    clear_ram(0);
    load_basic(1023);
    exp_basic(1023);
    run(0, 2);

    // P=1, Q=1 instance; upper lanes carry junk that must be ignored
    clear_ram(1);
    wr(1, 10'd0,    desc(16'h20, 16'h10, 16'h08));
    wr(1, 10'd8,    64'hDEAD_BEEF_1234_0003);
    wr(1, 10'd16,   64'h7FFF_8000_5555_FFFC);
    wr(1, 10'h21,   64'h0123_4567_89AB_CDEF);
    exp_item(1, 0, 10'h20, 64'h0000_0000_FFFF_FFF4);
    exp_item(1, 0, 10'h21, 64'h0123_4567_89AB_CDEF);
    exp_regs(1, 8'hF4, 1);
    run(1, 1);

    repeat (4) @(negedge clk);
    check("uart_queue_drained", 64'(exp_tx_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
